// File: rtl/regdst_track.sv
// Destination-register select plus DEPTH-stage in-flight destination tracker with hazard flags.
// Optional REGDST_FWD_PRIO_EN adds youngest-match forwarding indices.
module regdst_track #(
    parameter int WIDTH   = 5,
    parameter int NUM_SRC = 3,
    parameter int SEL_W   = 2,
    parameter int DEPTH   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_SRC*WIDTH-1:0] src_bus,
    input  logic [SEL_W-1:0]         dst_sel,
    input  logic                     in_valid,
    input  logic                     reg_write,
    input  logic                     stall,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         rs_addr,
    input  logic [WIDTH-1:0]         rt_addr,
    output logic [WIDTH-1:0]         dst_out,
    output logic                     dst_valid,
    output logic [WIDTH-1:0]         wb_dst,
    output logic                     wb_valid,
    output logic [DEPTH-1:0]         hazard_rs,
    output logic [DEPTH-1:0]         hazard_rt
`ifdef REGDST_FWD_PRIO_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] fwd_rs_idx,
    output logic [$clog2(DEPTH+1)-1:0] fwd_rt_idx
`endif
);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [WIDTH-1:0] addr_q [DEPTH];
    logic [WIDTH-1:0] addr_d [DEPTH];
    logic [WIDTH-1:0] sel_dst;
    logic             next_v0;

    // Out-of-range selector falls through to $0, which never becomes valid.
    always_comb begin
        sel_dst = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (32'(dst_sel) == i) begin
                sel_dst = src_bus[i*WIDTH +: WIDTH];
            end
        end
        next_v0 = in_valid & reg_write & (sel_dst != '0);
    end

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            valid_d[k] = valid_q[k-1];
            addr_d[k]  = addr_q[k-1];
        end
        if (flush) begin
            valid_d[0] = 1'b0;
            addr_d[0]  = '0;
        end else if (stall) begin
            valid_d[0] = valid_q[0];
            addr_d[0]  = addr_q[0];
            valid_d[1] = 1'b0;
            addr_d[1]  = '0;
        end else begin
            valid_d[0] = next_v0;
            addr_d[0]  = sel_dst;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                addr_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                addr_q[k] <= addr_d[k];
            end
        end
    end

    assign dst_out   = addr_q[0];
    assign dst_valid = valid_q[0];
    assign wb_dst    = addr_q[DEPTH-1];
    assign wb_valid  = valid_q[DEPTH-1];

    always_comb begin
        hazard_rs = '0;
        hazard_rt = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            hazard_rs[k] = valid_q[k] & (addr_q[k] == rs_addr) & (rs_addr != '0);
            hazard_rt[k] = valid_q[k] & (addr_q[k] == rt_addr) & (rt_addr != '0);
        end
    end

`ifdef REGDST_FWD_PRIO_EN
    localparam int IDX_W = $clog2(DEPTH+1);

    // Scan oldest to youngest so the youngest match is the last one written.
    always_comb begin
        fwd_rs_idx = '0;
        fwd_rt_idx = '0;
        for (int unsigned j = 0; j < DEPTH; j++) begin
            if (hazard_rs[DEPTH-1-j]) fwd_rs_idx = IDX_W'(DEPTH - j);
            if (hazard_rt[DEPTH-1-j]) fwd_rt_idx = IDX_W'(DEPTH - j);
        end
    end
`endif

endmodule

// File: tb/tb_regdst_track.sv
// Randomized scoreboard bench for regdst_track against a queue-based pipeline model.
// Define REGDST_FWD_PRIO_EN to also check the forwarding indices.
module tb_regdst_track;

    localparam int WIDTH   = 5;
    localparam int NUM_SRC = 3;
    localparam int SEL_W   = 2;
    localparam int DEPTH   = 3;
    localparam int IDX_W   = $clog2(DEPTH+1);

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [NUM_SRC*WIDTH-1:0] src_bus = '0;
    logic [SEL_W-1:0]         dst_sel = '0;
    logic                     in_valid = 1'b0;
    logic                     reg_write = 1'b0;
    logic                     stall = 1'b0;
    logic                     flush = 1'b0;
    logic [WIDTH-1:0]         rs_addr = '0;
    logic [WIDTH-1:0]         rt_addr = '0;
    logic [WIDTH-1:0]         dst_out, wb_dst;
    logic                     dst_valid, wb_valid;
    logic [DEPTH-1:0]         hazard_rs, hazard_rt;
`ifdef REGDST_FWD_PRIO_EN
    logic [IDX_W-1:0]         fwd_rs_idx, fwd_rt_idx;
`endif

    regdst_track #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .src_bus(src_bus), .dst_sel(dst_sel),
        .in_valid(in_valid), .reg_write(reg_write), .stall(stall), .flush(flush),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .dst_out(dst_out), .dst_valid(dst_valid), .wb_dst(wb_dst), .wb_valid(wb_valid),
        .hazard_rs(hazard_rs), .hazard_rt(hazard_rt)
`ifdef REGDST_FWD_PRIO_EN
        , .fwd_rs_idx(fwd_rs_idx), .fwd_rt_idx(fwd_rt_idx)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       v;
        int       a;
    } ent_t;

    typedef struct {
        int dst, dv, wb, wv, hrs, hrt, frs, frt;
    } exp_t;

    ent_t pipe[$];
    exp_t sbq[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_clear();
        pipe.delete();
        for (int i = 0; i < DEPTH; i++) pipe.push_back('{v: 1'b0, a: 0});
    endtask

    function automatic exp_t model_outputs(input int rs, input int rt);
        exp_t e;
        e.dst = pipe[0].a;
        e.dv  = int'(pipe[0].v);
        e.wb  = pipe[DEPTH-1].a;
        e.wv  = int'(pipe[DEPTH-1].v);
        e.hrs = 0; e.hrt = 0; e.frs = 0; e.frt = 0;
        for (int k = 0; k < DEPTH; k++) begin
            if (pipe[k].v && pipe[k].a == rs && rs != 0) begin
                e.hrs += (1 << k);
                if (e.frs == 0) e.frs = k + 1;
            end
            if (pipe[k].v && pipe[k].a == rt && rt != 0) begin
                e.hrt += (1 << k);
                if (e.frt == 0) e.frt = k + 1;
            end
        end
        return e;
    endfunction

    // Drive one instruction slot at the falling edge and queue the state expected after the next rising edge.
    task automatic step(input int c2, input int c1, input int c0, input int sel,
                        input bit iv, input bit rw, input bit st, input bit fl,
                        input int rs, input int rt);
        int   cand[NUM_SRC];
        int   seld;
        ent_t e;
        @(negedge clk);
        src_bus   = {WIDTH'(c2), WIDTH'(c1), WIDTH'(c0)};
        dst_sel   = SEL_W'(sel);
        in_valid  = iv;
        reg_write = rw;
        stall     = st;
        flush     = fl;
        rs_addr   = WIDTH'(rs);
        rt_addr   = WIDTH'(rt);
        cand[0] = c0; cand[1] = c1; cand[2] = c2;
        seld = (sel < NUM_SRC) ? cand[sel] : 0;
        if (fl) begin
            pipe.push_front('{v: 1'b0, a: 0});
            void'(pipe.pop_back());
        end else if (st) begin
            pipe.insert(1, '{v: 1'b0, a: 0});
            void'(pipe.pop_back());
        end else begin
            e.v = iv && rw && (seld != 0);
            e.a = seld;
            pipe.push_front(e);
            void'(pipe.pop_back());
        end
        sbq.push_back(model_outputs(rs, rt));
    endtask

    task automatic rand_step();
        step($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 3), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
             $urandom_range(0, 7), $urandom_range(0, 7));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dst_out"}, int'(dst_out), 0);
        chk({tag, "_dst_valid"}, int'(dst_valid), 0);
        chk({tag, "_wb_dst"}, int'(wb_dst), 0);
        chk({tag, "_wb_valid"}, int'(wb_valid), 0);
        chk({tag, "_hazard_rs"}, int'(hazard_rs), 0);
        chk({tag, "_hazard_rt"}, int'(hazard_rt), 0);
`ifdef REGDST_FWD_PRIO_EN
        chk({tag, "_fwd_rs"}, int'(fwd_rs_idx), 0);
        chk({tag, "_fwd_rt"}, int'(fwd_rt_idx), 0);
`endif
    endtask

    // Monitor: one expected record per rising edge, sampled 2 time units after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("dst_out", int'(dst_out), e.dst);
                chk("dst_valid", int'(dst_valid), e.dv);
                chk("wb_dst", int'(wb_dst), e.wb);
                chk("wb_valid", int'(wb_valid), e.wv);
                chk("hazard_rs", int'(hazard_rs), e.hrs);
                chk("hazard_rt", int'(hazard_rt), e.hrt);
`ifdef REGDST_FWD_PRIO_EN
                chk("fwd_rs_idx", int'(fwd_rs_idx), e.frs);
                chk("fwd_rt_idx", int'(fwd_rt_idx), e.frt);
`endif
            end
        end
    end

    initial begin
        int guard;
        model_clear();
        repeat (2) @(posedge clk);
        #3;
        chk_all_zero("por");
        rst = 1'b0;

        // Select candidate 1 (=12) and let it walk to WB.
        step(31, 12, 9, 1, 1, 1, 0, 0, 12, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 12, 0);

        // Out-of-range select, zero candidate, no reg_write.
        step(31, 12, 9, 3, 1, 1, 0, 0, 0, 0);
        step(31, 12, 0, 0, 1, 1, 0, 0, 0, 0);
        step(7, 7, 7, 1, 1, 0, 0, 0, 7, 7);

        // Stall two cycles holding 12, then release.
        step(31, 12, 9, 1, 1, 1, 0, 0, 12, 12);
        step(1, 2, 3, 0, 1, 1, 1, 0, 12, 3);
        step(1, 2, 3, 0, 1, 1, 1, 0, 12, 3);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 12, 0);

        // Flush beats stall while older entries still advance.
        step(0, 0, 6, 0, 1, 1, 0, 0, 0, 0);
        step(0, 0, 4, 0, 1, 1, 0, 0, 0, 0);
        step(0, 0, 5, 0, 1, 1, 1, 1, 4, 6);
        step(0, 0, 0, 0, 0, 0, 0, 0, 4, 6);

        // Build {8,8,3} in stages 0..2 and read the hazard pattern.
        step(0, 0, 3, 0, 1, 1, 0, 0, 0, 0);
        step(0, 0, 8, 0, 1, 1, 0, 0, 0, 0);
        step(0, 0, 8, 0, 1, 1, 0, 0, 8, 3);
        @(posedge clk);
        #3;
        chk("dir_hazard_rs", int'(hazard_rs), 3);
        chk("dir_hazard_rt", int'(hazard_rt), 4);
`ifdef REGDST_FWD_PRIO_EN
        chk("dir_fwd_rs", int'(fwd_rs_idx), 1);
        chk("dir_fwd_rt", int'(fwd_rt_idx), 3);
        rs_addr = 5'd20;
        #1;
        chk("dir_fwd_nomatch", int'(fwd_rs_idx), 0);
`endif
        rs_addr = 5'd0;
        #1;
        chk("dir_hazard_rs0", int'(hazard_rs), 0);

        repeat (400) rand_step();

        // Asynchronous reset mid-cycle with a loaded pipeline; inputs are toggled while held.
        step(0, 0, 9, 0, 1, 1, 0, 0, 9, 9);
        step(0, 0, 10, 0, 1, 1, 0, 0, 9, 10);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        model_clear();
        @(negedge clk);
        src_bus = {5'd11, 5'd11, 5'd11}; in_valid = 1'b1; reg_write = 1'b1;
        stall = 1'b0; flush = 1'b0; rs_addr = 5'd11; rt_addr = 5'd11;
        @(posedge clk);
        #3;
        chk_all_zero("rst_hold");
        rst = 1'b0;

        repeat (400) rand_step();

        guard = 0;
        while (sbq.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #3;
        chk("scoreboard_drained", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
